// File: rtl/cnn_accel_mc_if.sv
// Handshake and memory-port bundle for the multi-channel CNN accelerator.
// The engine connects through the slave modport; the controller/memory side uses master.
interface cnn_accel_mc_if #(
  parameter int DWIDTH = 32,
  parameter int HEIGHT = 8,
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int CIN    = 4
);
  localparam int HW = $clog2(HEIGHT);
  localparam int WW = $clog2(WIDTH);
  localparam int CW = (CIN > 1) ? $clog2(CIN) : 1;

  logic                    start;
  logic                    relu_en;
  logic                    busy;
  logic                    done;
  logic                    rd_en;
  logic [HW-1:0]           rd_haddr;
  logic [WW-1:0]           rd_waddr;
  logic [CW-1:0]           rd_ch;
  logic [DWIDTH-1:0]       rd_data;
  logic [DWIDTH*DEPTH-1:0] rd_cdata;
  logic                    wr_en;
  logic [HW-1:0]           wr_haddr;
  logic [WW-1:0]           wr_waddr;
  logic [DWIDTH*DEPTH-1:0] wr_data;

  modport slave (
    input  start, relu_en, rd_data, rd_cdata,
    output busy, done, rd_en, rd_haddr, rd_waddr, rd_ch,
           wr_en, wr_haddr, wr_waddr, wr_data
  );

  modport master (
    output start, relu_en, rd_data, rd_cdata,
    input  busy, done, rd_en, rd_haddr, rd_waddr, rd_ch,
           wr_en, wr_haddr, wr_waddr, wr_data
  );
endinterface

// File: rtl/cnn_accel_mc.sv
// Start/done CNN engine: sweeps HEIGHTxWIDTH pixels over CIN channels, DEPTH-lane MAC,
// signed saturation, optional ReLU, write-back of one result word per pixel.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_RUN   | issuing one read per cycle
// S_DRAIN | two cycles flushing the MAC and write pipeline
// S_DONE  | one-cycle done pulse
module cnn_accel_mc #(
  parameter int DWIDTH = 32,
  parameter int HEIGHT = 8,
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int CIN    = 4
) (
  input  logic           clk,
  input  logic           reset,
  cnn_accel_mc_if.slave  bus
);
  localparam int HW = $clog2(HEIGHT);
  localparam int WW = $clog2(WIDTH);
  localparam int CW = (CIN > 1) ? $clog2(CIN) : 1;
  localparam int PW = 2 * DWIDTH;
  localparam int AW = PW + CW;
  localparam logic [HW-1:0] H_MAX = HW'(HEIGHT - 1);
  localparam logic [WW-1:0] W_MAX = WW'(WIDTH - 1);
  localparam logic [CW-1:0] C_MAX = CW'(CIN - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t r_state, w_state_nxt;
  logic   r_drain_cnt;
  logic   w_start_acc;
  logic   w_last_rd;

  logic          r_rd_en;
  logic [HW-1:0] r_rd_h;
  logic [WW-1:0] r_rd_w;
  logic [CW-1:0] r_rd_c;
  logic          r_relu;

  logic          r_p_valid;
  logic [HW-1:0] r_p_h;
  logic [WW-1:0] r_p_w;
  logic [CW-1:0] r_p_c;

  logic signed [AW-1:0]    r_acc     [DEPTH];
  logic signed [AW-1:0]    w_acc_nxt [DEPTH];
  logic signed [PW-1:0]    w_prod    [DEPTH];
  logic [DWIDTH*DEPTH-1:0] w_res;

  logic                    r_wr_en;
  logic [HW-1:0]           r_wr_h;
  logic [WW-1:0]           r_wr_w;
  logic [DWIDTH*DEPTH-1:0] r_wr_data;

  assign w_last_rd = (r_rd_c == C_MAX) && (r_rd_w == W_MAX) && (r_rd_h == H_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_drain_cnt <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (r_state != S_DRAIN)
        r_drain_cnt <= 1'b1;
      else if (r_drain_cnt != 1'b0)
        r_drain_cnt <= r_drain_cnt - 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_RUN;
          w_start_acc = 1'b1;
        end
      end
      S_RUN:   if (w_last_rd) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_drain_cnt == 1'b0) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Per-lane MAC, saturation and ReLU on the cycle the read data is present.
  always_comb begin
    logic [DWIDTH-1:0] w_sat;
    logic [AW-DWIDTH:0] w_top;
    w_res = '0;
    w_sat = '0;
    w_top = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_prod[k]    = PW'($signed(bus.rd_data)) * PW'($signed(bus.rd_cdata[k*DWIDTH +: DWIDTH]));
      w_acc_nxt[k] = (r_p_c == '0) ? AW'(w_prod[k]) : r_acc[k] + AW'(w_prod[k]);
      w_top        = w_acc_nxt[k][AW-1:DWIDTH-1];
      if ((&w_top) || !(|w_top))
        w_sat = w_acc_nxt[k][DWIDTH-1:0];
      else
        w_sat = {w_top[AW-DWIDTH], {(DWIDTH-1){~w_top[AW-DWIDTH]}}};
      if (r_relu && w_sat[DWIDTH-1])
        w_sat = '0;
      w_res[k*DWIDTH +: DWIDTH] = w_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_en   <= 1'b0;
      r_rd_h    <= '0;
      r_rd_w    <= '0;
      r_rd_c    <= '0;
      r_relu    <= 1'b0;
      r_p_valid <= 1'b0;
      r_p_h     <= '0;
      r_p_w     <= '0;
      r_p_c     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_h    <= '0;
      r_wr_w    <= '0;
      r_wr_data <= '0;
      for (int k = 0; k < DEPTH; k++) r_acc[k] <= '0;
    end else begin
      if (w_start_acc) begin
        r_rd_en <= 1'b1;
        r_rd_h  <= '0;
        r_rd_w  <= '0;
        r_rd_c  <= '0;
        r_relu  <= bus.relu_en;
      end else if (r_state == S_RUN) begin
        if (w_last_rd) begin
          r_rd_en <= 1'b0;
        end else if (r_rd_c == C_MAX) begin
          r_rd_c <= '0;
          if (r_rd_w == W_MAX) begin
            r_rd_w <= '0;
            r_rd_h <= (r_rd_h == H_MAX) ? '0 : r_rd_h + 1'b1;
          end else begin
            r_rd_w <= r_rd_w + 1'b1;
          end
        end else begin
          r_rd_c <= r_rd_c + 1'b1;
        end
      end

      r_p_valid <= r_rd_en;
      if (r_rd_en) begin
        r_p_h <= r_rd_h;
        r_p_w <= r_rd_w;
        r_p_c <= r_rd_c;
      end

      if (r_p_valid)
        for (int k = 0; k < DEPTH; k++) r_acc[k] <= w_acc_nxt[k];

      r_wr_en <= r_p_valid && (r_p_c == C_MAX);
      if (r_p_valid && (r_p_c == C_MAX)) begin
        r_wr_h    <= r_p_h;
        r_wr_w    <= r_p_w;
        r_wr_data <= w_res;
      end
    end
  end

  assign bus.busy     = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign bus.done     = (r_state == S_DONE);
  assign bus.rd_en    = r_rd_en;
  assign bus.rd_haddr = r_rd_h;
  assign bus.rd_waddr = r_rd_w;
  assign bus.rd_ch    = r_rd_c;
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_haddr = r_wr_h;
  assign bus.wr_waddr = r_wr_w;
  assign bus.wr_data  = r_wr_data;
endmodule

// File: tb/tb_cnn_accel_mc.sv
// Scoreboard bench for cnn_accel_mc: stimulus pushes expected reads, writes and done
// cycles from an arithmetic reference; a negedge monitor pops and compares.
module tb_cnn_accel_mc;
  localparam int DW = 8, H = 2, W = 2, D = 2, CI = 2;
  localparam int N = H * W * CI;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cnn_accel_mc_if #(.DWIDTH(DW), .HEIGHT(H), .WIDTH(W), .DEPTH(D), .CIN(CI)) u_if ();
  cnn_accel_mc #(.DWIDTH(DW), .HEIGHT(H), .WIDTH(W), .DEPTH(D), .CIN(CI)) dut (
    .clk(clk), .reset(reset), .bus(u_if.slave)
  );

  int checks = 0, failures = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [DW-1:0] img [N];
  logic signed [DW-1:0] cf  [N][D];

  typedef struct {int cyc; int h; int w; int c;} rd_t;
  typedef struct {int cyc; int h; int w; logic [D*DW-1:0] data;} wr_t;
  rd_t rdq[$];
  wr_t wrq[$];
  int  doneq[$];
  int  busy_lo = 1, busy_hi = 0;
  rd_t er;
  wr_t ew;
  int  ed;

  function automatic int idx(int h, int w, int c);
    return (h * W + w) * CI + c;
  endfunction

  function automatic logic [D*DW-1:0] cvec(int i);
    logic [D*DW-1:0] v;
    for (int k = 0; k < D; k++) v[k*DW +: DW] = cf[i][k];
    return v;
  endfunction

  task automatic check(input string name, input bit ok, input string detail);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // Memory model: one-cycle read latency, garbage on idle cycles.
  always @(posedge clk) begin
    if (u_if.rd_en) begin
      u_if.rd_data  <= img[idx(int'(u_if.rd_haddr), int'(u_if.rd_waddr), int'(u_if.rd_ch))];
      u_if.rd_cdata <= cvec(idx(int'(u_if.rd_haddr), int'(u_if.rd_waddr), int'(u_if.rd_ch)));
    end else begin
      u_if.rd_data  <= DW'($urandom);
      u_if.rd_cdata <= (D*DW)'($urandom);
    end
  end

  always @(negedge clk) begin
    check("busy", u_if.busy == (cyc >= busy_lo && cyc <= busy_hi),
          $sformatf("cyc %0d busy got %0b want %0b", cyc, u_if.busy, (cyc >= busy_lo && cyc <= busy_hi)));
    if (u_if.rd_en) begin
      if (rdq.size() == 0) check("rd_unexpected", 1'b0, $sformatf("cyc %0d got read, want none", cyc));
      else begin
        er = rdq.pop_front();
        check("rd", cyc == er.cyc && int'(u_if.rd_haddr) == er.h && int'(u_if.rd_waddr) == er.w
                    && int'(u_if.rd_ch) == er.c,
              $sformatf("got cyc %0d h%0d w%0d c%0d want cyc %0d h%0d w%0d c%0d", cyc, u_if.rd_haddr,
                        u_if.rd_waddr, u_if.rd_ch, er.cyc, er.h, er.w, er.c));
      end
    end
    if (u_if.wr_en) begin
      if (wrq.size() == 0) check("wr_unexpected", 1'b0, $sformatf("cyc %0d got write, want none", cyc));
      else begin
        ew = wrq.pop_front();
        check("wr", cyc == ew.cyc && int'(u_if.wr_haddr) == ew.h && int'(u_if.wr_waddr) == ew.w
                    && u_if.wr_data == ew.data,
              $sformatf("got cyc %0d h%0d w%0d data %h want cyc %0d h%0d w%0d data %h", cyc,
                        u_if.wr_haddr, u_if.wr_waddr, u_if.wr_data, ew.cyc, ew.h, ew.w, ew.data));
      end
    end
    if (u_if.done) begin
      if (doneq.size() == 0) check("done_unexpected", 1'b0, $sformatf("cyc %0d got done, want none", cyc));
      else begin
        ed = doneq.pop_front();
        check("done", cyc == ed, $sformatf("got done cyc %0d want %0d", cyc, ed));
      end
    end
  end

  // Reference: plain dot products over channels, clamp to signed DW, optional ReLU.
  task automatic build_expect(input int c0, input bit relu);
    longint s;
    logic [D*DW-1:0] data;
    for (int i = 0; i < N; i++)
      rdq.push_back('{c0 + 1 + i, i / (CI * W), (i / CI) % W, i % CI});
    for (int p = 0; p < H * W; p++) begin
      data = '0;
      for (int k = 0; k < D; k++) begin
        s = 0;
        for (int c = 0; c < CI; c++)
          s += longint'(img[idx(p / W, p % W, c)]) * longint'(cf[idx(p / W, p % W, c)][k]);
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        if (relu && s < 0) s = 0;
        data[k*DW +: DW] = s[DW-1:0];
      end
      wrq.push_back('{c0 + (p + 1) * CI + 2, p / W, p % W, data});
    end
    doneq.push_back(c0 + N + 3);
    busy_lo = c0 + 1;
    busy_hi = c0 + N + 2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pass(input bit relu);
    build_expect(cyc, relu);
    u_if.start   = 1'b1;
    u_if.relu_en = relu;
    tick();
    u_if.start   = 1'b0;
    u_if.relu_en = ~relu;
  endtask

  task automatic run_pass(input bit relu);
    start_pass(relu);
    repeat (N + 3) tick();
  endtask

  task automatic load(input int i0, input int i1, input int a0, input int a1, input int b0, input int b1);
    for (int h = 0; h < H; h++)
      for (int w = 0; w < W; w++) begin
        img[idx(h, w, 0)] = DW'(i0);
        img[idx(h, w, 1)] = DW'(i1);
        cf[idx(h, w, 0)][0] = DW'(a0);
        cf[idx(h, w, 0)][1] = DW'(a1);
        cf[idx(h, w, 1)][0] = DW'(b0);
        cf[idx(h, w, 1)][1] = DW'(b1);
      end
  endtask

  task automatic load_rand();
    for (int i = 0; i < N; i++) begin
      img[i] = DW'($urandom);
      for (int k = 0; k < D; k++) cf[i][k] = DW'($urandom);
    end
  endtask

  task automatic check_idle_zero(input string name);
    @(negedge clk);
    check(name, {u_if.busy, u_if.done, u_if.rd_en, u_if.wr_en} == 4'b0 && u_if.rd_haddr == '0
                && u_if.rd_waddr == '0 && u_if.rd_ch == '0 && u_if.wr_haddr == '0
                && u_if.wr_waddr == '0 && u_if.wr_data == '0,
          $sformatf("cyc %0d got busy%0b done%0b rd%0b wr%0b ra %0d/%0d/%0d wa %0d/%0d wd %h want all 0",
                    cyc, u_if.busy, u_if.done, u_if.rd_en, u_if.wr_en, u_if.rd_haddr, u_if.rd_waddr,
                    u_if.rd_ch, u_if.wr_haddr, u_if.wr_waddr, u_if.wr_data));
    tick();
  endtask

  int c0;

  initial begin
    u_if.start   = 1'b0;
    u_if.relu_en = 1'b0;
    load(3, 3, 2, -1, 2, -1);
    repeat (3) tick();
    check_idle_zero("reset_state");
    reset = 1'b0;
    repeat (2) tick();

    run_pass(1'b0);                    // basic: 12 / -6
    run_pass(1'b1);                    // ReLU: 12 / 0
    load(100, 100, 100, -100, 100, -100);
    run_pass(1'b0);                    // saturation: 127 / -128
    load(1, 2, 5, 5, 7, 7);
    run_pass(1'b0);                    // per-channel accumulate: 19

    // Protocol: starts in RUN and DONE are ignored; next start accepted right after.
    load(3, 3, 2, -1, 2, -1);
    c0 = cyc;
    start_pass(1'b0);
    repeat (2) tick();
    u_if.start = 1'b1;
    tick();
    u_if.start = 1'b0;
    while (cyc < c0 + 11) tick();
    u_if.start = 1'b1;
    tick();
    run_pass(1'b0);

    // Reset in cycle 5 of a pass.
    c0 = cyc;
    start_pass(1'b0);
    while (cyc < c0 + 5) tick();
    reset   = 1'b1;
    busy_hi = c0 + 5;
    tick();
    reset = 1'b0;
    rdq.delete();
    wrq.delete();
    doneq.delete();
    repeat (4) check_idle_zero("post_reset");
    run_pass(1'b0);

    for (int r = 0; r < 6; r++) begin
      load_rand();
      run_pass(1'($urandom));
    end

    repeat (4) tick();
    check("rdq_empty", rdq.size() == 0, $sformatf("got %0d pending reads want 0", rdq.size()));
    check("wrq_empty", wrq.size() == 0, $sformatf("got %0d pending writes want 0", wrq.size()));
    check("doneq_empty", doneq.size() == 0, $sformatf("got %0d pending done want 0", doneq.size()));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cnn_accel_mc.md
# cnn_accel_mc

Multi-channel successor to the CNN accelerator top level. The block is a start/done-controlled engine that sweeps a HEIGHT×WIDTH image over CIN input channels and computes DEPTH output-channel dot products per pixel. Each result is signed-saturated, optionally ReLU-clamped, and written back through a write port. It sits between the image/coefficient memories (read ports, 1-cycle latency) and the output memory (write port), replacing the free-running, read-only path with a complete read–compute–write pass.

## Interface
Parameters:
- DWIDTH, 32, signed data/coefficient word width (≥4)
- HEIGHT, 8, image rows (≥2)
- WIDTH, 8, image columns (≥2)
- DEPTH, 8, output channels (coefficient lanes, ≥1)
- CIN, 4, input channels accumulated per pixel (≥1)

Ports (clock and reset first). Reset is synchronous and active-high; the block uses one clock.
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a pass; accepted only in IDLE
- relu_en  in  1  sampled when start is accepted; held for the pass
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse at the end of the pass
- rd_en  out  1  read strobe to the image and coefficient memories
- rd_haddr  out  $clog2(HEIGHT)  row address
- rd_waddr  out  $clog2(WIDTH)  column address
- rd_ch  out  max(1,$clog2(CIN))  input-channel address; 0 when CIN=1
- rd_data  in  DWIDTH  image word, valid the cycle after rd_en
- rd_cdata  in  DWIDTH*DEPTH  coefficients, lane k at [(k+1)*DWIDTH-1:k*DWIDTH], valid the cycle after rd_en
- wr_en  out  1  output write strobe
- wr_haddr  out  $clog2(HEIGHT)  output row
- wr_waddr  out  $clog2(WIDTH)  output column
- wr_data  out  DWIDTH*DEPTH  results, lane k as in rd_cdata

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN on start.
  - RUN→DRAIN after the final read is issued.
  - DRAIN lasts 2 cycles, then →DONE.
  - DONE lasts 1 cycle, then →IDLE.
- start is ignored in RUN, DRAIN and DONE.
- Read order: channel fastest, then column, then row. Loops are c=0..CIN-1, w=0..WIDTH-1, h=0..HEIGHT-1.
- RUN issues exactly one read per cycle with no gaps, HEIGHT·WIDTH·CIN reads in total.
- Counters wrap to 0 at each limit. Carries propagate channel→column→row.
- MAC per lane k, on the cycle data is present:
  - product = rd_data × lane k, signed, 2·DWIDTH bits.
  - accumulator is 2·DWIDTH+max(1,$clog2(CIN)) bits.
  - For c=0 the accumulator loads the product; otherwise it adds the product.
- On the last channel of a pixel, the final sum is saturated to signed DWIDTH, giving a range of [−2^(DWIDTH−1), 2^(DWIDTH−1)−1].
- If the latched relu_en is 1, negative results are forced to 0.
- The processed result is registered into wr_data together with the pixel's (h,w).
- Write addresses are pipelined copies of the read addresses. They are never recomputed.
- Reset values: state IDLE; busy, done, rd_en and wr_en are 0; all address outputs and wr_data are 0; accumulators are 0.
- Reset asserted mid-pass:
  - Next cycle all outputs take reset values.
  - In-flight results are discarded, with no wr_en.
  - done does not pulse.
- Address outputs hold their last value when the associated strobe is low.

## Timing
- Cycle 0: start=1 in IDLE. Cycle 1: first rd_en, and busy rises.
- Let N = HEIGHT·WIDTH·CIN. rd_en is high in cycles 1..N.
- A read issued in cycle t has its data consumed in cycle t+1.
- Write timing: for a pixel whose last read is in cycle t, wr_en is high in cycle t+2.
- The last wr_en is in cycle N+2. busy is high in cycles 1..N+2.
- done is high in cycle N+3 (DONE state). The earliest next start is accepted in cycle N+4.
- wr_en is high for exactly HEIGHT·WIDTH cycles per pass. With CIN=1 these writes are back-to-back.

## Test plan
Configuration for all scenarios: DWIDTH=8, HEIGHT=2, WIDTH=2, CIN=2, DEPTH=2.
- Basic pass: image all 3, lane0 coeff 2, lane1 coeff −1, relu_en=0, start in cycle 0. Required: rd_en in cycles 1–8; wr_en in cycles 4, 6, 8, 10 at (h,w)=(0,0),(0,1),(1,0),(1,1); lane0=12, lane1=−6 (0xFA); done only in cycle 11.
- ReLU: same stimulus with relu_en=1. Required: lane0=12, lane1=0 at every write.
- Saturation: image 100; lane0 coeff 100, lane1 coeff −100. Required: lane0=127, lane1=−128 (0x80) with relu_en=0.
- Per-channel accumulate: image word = 1+c, coeffs = 5 on channel 0 and 7 on channel 1. Required: lane result 5+14=19, proving the c=0 load does not carry over the previous pixel.
- Protocol: start pulsed in cycles 3 and 11 of a pass, then in cycle 12. Required: the first two starts are ignored; a second pass begins with rd_en in cycle 13; done pulses exactly once per pass.
- Reset at cycle 5 of a pass. Required: from cycle 6 busy, rd_en, wr_en and done are 0 and all addresses are 0; no further writes; a new start after reset yields the basic-pass results.
